fetch_unit: RTL and testbench

//  Instruction fetch stage for the RV32I datapath: owns the program counter, issues word reads to

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_if.sv | 25 ++
 rtl/fetch_queue.sv | 52 +++++
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    localparam int unsigned INST_BYTES    = 4;
    localparam logic [31:0] NOP_INST      = 32'h0000_0013;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Force a fetch target onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/ack bus and decode-side valid/ready bus of the fetch stage.
interface fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    // Fetch stage side.
    modport master (
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_ack, imem_rdata, inst_ready
    );

    // Memory and decode side.
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        output imem_ack, imem_rdata, inst_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, inst} pairs; flush beats push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    localparam int unsigned PTR_W = CNT_W - 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage, written at the tail on every accepted push.
    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC register, single-outstanding imem request FSM, redirect/flush handling.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic             clock,
    input  logic             reset,
    fetch_if.master          bus,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] queue_count
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  fetch_pc;
    logic         credit;
    logic         accept_ack;
    logic         pop;
    logic         q_full;
    logic         q_empty;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    // At most one request is ever in flight, so a free queue slot is the whole credit check.
    assign credit     = !q_full;
    assign accept_ack = (state == ST_WAIT) && bus.imem_ack && !redirect;
    assign push_entry = '{pc: fetch_pc, inst: bus.imem_rdata};

    assign bus.imem_addr  = fetch_pc;
    assign bus.inst_valid = !q_empty && !redirect;
    assign bus.inst_data  = q_empty ? '0 : head_entry.inst;
    assign bus.inst_pc    = q_empty ? '0 : head_entry.pc;
    assign pop            = bus.inst_valid && bus.inst_ready;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) state <= ST_REQ;
        else        state <= state_next;
    end

    // Program counter: redirect target, else advance on each accepted word.
    always_ff @(posedge clock) begin
        if (!reset)          fetch_pc <= RESET_PC;
        else if (redirect)   fetch_pc <= align_pc(redirect_pc);
        else if (accept_ack) fetch_pc <= fetch_pc + 32'(INST_BYTES);
    end

    // Next-state logic; a redirect without its ack leaves a stale response to swallow in DRAIN.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_REQ:   if (bus.imem_req) state_next = ST_WAIT;
            ST_WAIT: begin
                if (bus.imem_ack)   state_next = ST_REQ;
                else if (redirect)  state_next = ST_DRAIN;
            end
            ST_DRAIN: if (bus.imem_ack) state_next = ST_REQ;
            default:  state_next = ST_REQ;
        endcase
    end

    // Request output; a redirect in REQ withholds the request so the stale PC is never issued.
    always_comb begin
        bus.imem_req = 1'b0;
        unique case (state)
            ST_REQ:  bus.imem_req = credit && !redirect;
            ST_WAIT: bus.imem_req = 1'b1;
            default: bus.imem_req = 1'b0;
        endcase
        if (!reset) bus.imem_req = 1'b0;
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (accept_ack),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .head      (head_entry),
        .count     (queue_count),
        .full      (q_full),
        .empty     (q_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural instruction memory and an instruction scoreboard.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CNT_W    = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] queue_count;

    fetch_if bus ();

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .queue_count (queue_count)
    );

    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    logic [63:0] sb [$];
    logic [31:0] got_pc [$];
    int unsigned got_cyc [$];

    bit          pending     = 1'b0;
    bit          discard_next = 1'b0;
    int unsigned mem_cnt     = 0;
    int unsigned mem_lat     = 1;
    logic [31:0] paddr       = '0;
    logic [31:0] exp_addr    = RESET_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ NOP_INST;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, then advance memory model just after the posedge.
    task automatic cycle();
        logic        req_now;
        logic        ack_now;
        logic [31:0] addr_now;
        logic [63:0] exp_e;
        bit          new_req;
        @(negedge clock);
        cyc++;
        req_now  = bus.imem_req;
        ack_now  = bus.imem_ack;
        addr_now = bus.imem_addr;
        if (bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
            got_pc.push_back(bus.inst_pc);
            got_cyc.push_back(cyc);
            n_checks++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL extra_inst: observed pc %h with nothing expected", bus.inst_pc);
            end
            if (sb.size() != 0) begin
                exp_e = sb.pop_front();
                check("inst_pc_data", {bus.inst_pc, bus.inst_data}, exp_e);
            end
        end
        new_req = (req_now === 1'b1) && !pending;
        if (new_req) check("imem_addr", addr_now, exp_addr);
        @(posedge clock);
        #1;
        redirect = 1'b0;
        if (ack_now === 1'b1) pending = 1'b0;
        if (new_req) begin
            pending = 1'b1;
            paddr   = addr_now;
            mem_cnt = mem_lat;
        end
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
        if (pending) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem_word(paddr);
                if (discard_next) begin
                    discard_next = 1'b0;
                end else begin
                    sb.push_back({paddr, mem_word(paddr)});
                    exp_addr = exp_addr + 32'd4;
                end
            end
        end
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        sb.delete();
        if (pending && bus.imem_ack !== 1'b1) discard_next = 1'b1;
        exp_addr = target & 32'hFFFF_FFFC;
    endtask

    task automatic wait_consumed(input int unsigned target, input string tag);
        int unsigned k = 0;
        while (got_pc.size() < target && k < 60) begin
            cycle();
            k++;
        end
        n_checks++;
        assert (got_pc.size() >= target) else begin
            n_fail++;
            $error("FAIL %s: observed %0d instructions expected %0d", tag, got_pc.size(), target);
        end
    endtask

    // Hard stop in case a sequence wedges outside a bounded wait.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned k;
        int unsigned m;
        int unsigned n;

        reset          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
        bus.inst_ready = 1'b0;

        // 1. Reset values, then in-order fetch at 1-cycle memory latency.
        repeat (3) cycle();
        #1;
        check("rst_imem_req", bus.imem_req, 1'b0);
        check("rst_inst_valid", bus.inst_valid, 1'b0);
        check("rst_inst_data", bus.inst_data, 32'h0);
        check("rst_inst_pc", bus.inst_pc, 32'h0);
        check("rst_queue_count", queue_count, 0);
        check("rst_imem_addr", bus.imem_addr, RESET_PC);

        reset = 1'b1;
        bus.inst_ready = 1'b1;
        #1;
        check("first_req", bus.imem_req, 1'b1);
        cycle();
        #1;
        check("valid_c1", bus.inst_valid, 1'b0);
        cycle();
        #1;
        check("valid_c2", bus.inst_valid, 1'b1);
        check("pc_c2", bus.inst_pc, 32'h0);
        wait_consumed(4, "t1_consume");
        check("t1_pc0", got_pc[0], 32'h0);
        check("t1_pc1", got_pc[1], 32'h4);
        check("t1_pc2", got_pc[2], 32'h8);
        check("t1_pc3", got_pc[3], 32'hC);
        check("t1_rate", got_cyc[3] - got_cyc[0], 6);

        // 2. Back-pressure fills the queue, a single pop re-opens fetching.
        bus.inst_ready = 1'b0;
        repeat (20) cycle();
        #1;
        check("t2_count_full", queue_count, 4);
        check("t2_req_full", bus.imem_req, 1'b0);
        check("t2_valid_full", bus.inst_valid, 1'b1);
        m = got_pc.size();
        bus.inst_ready = 1'b1;
        cycle();
        bus.inst_ready = 1'b0;
        #1;
        check("t2_count_pop", queue_count, 3);
        check("t2_req_resume", bus.imem_req, 1'b1);
        check("t2_addr_resume", bus.imem_addr, exp_addr);
        bus.inst_ready = 1'b1;
        wait_consumed(m + 7, "t2_consume");
        for (int i = int'(m) - 1; i < int'(m) + 6; i++)
            check("t2_seq", got_pc[i + 1], got_pc[i] + 32'd4);

        // 3. Redirect while a slow request is outstanding: its ack is dropped.
        bus.inst_ready = 1'b0;
        mem_lat = 1;
        k = 0;
        while (queue_count < 2 && k < 40) begin cycle(); k++; end
        check("t3_fill", (queue_count >= 2), 1'b1);
        mem_lat = 4;
        k = 0;
        while (!(pending && mem_cnt == 3) && k < 40) begin cycle(); k++; end
        check("t3_wait_found", (pending && mem_cnt == 3), 1'b1);
        #1;
        check("t3_valid_pre", bus.inst_valid, 1'b1);
        bus.inst_ready = 1'b1;
        do_redirect(32'h0000_0103);
        #1;
        check("t3_valid_redirect", bus.inst_valid, 1'b0);
        cycle();
        #1;
        check("t3_count_flushed", queue_count, 0);
        check("t3_req_drain", bus.imem_req, 1'b0);
        cycle();
        cycle();
        #1;
        check("t3_ack_arrives", bus.imem_ack, 1'b1);
        check("t3_req_drain_ack", bus.imem_req, 1'b0);
        mem_lat = 1;
        cycle();
        #1;
        check("t3_req_after", bus.imem_req, 1'b1);
        check("t3_addr_after", bus.imem_addr, 32'h0000_0100);
        check("t3_count_after", queue_count, 0);
        n = got_pc.size();
        wait_consumed(n + 1, "t3_consume");
        check("t3_first_pc", got_pc[n], 32'h0000_0100);

        // 4. Redirect in the same cycle as the ack.
        mem_lat = 2;
        k = 0;
        while (bus.imem_ack !== 1'b1 && k < 20) begin cycle(); k++; end
        check("t4_ack_found", bus.imem_ack, 1'b1);
        do_redirect(32'h0000_0200);
        cycle();
        #1;
        check("t4_count", queue_count, 0);
        check("t4_req", bus.imem_req, 1'b1);
        check("t4_addr", bus.imem_addr, 32'h0000_0200);
        n = got_pc.size();
        wait_consumed(n + 1, "t4_consume");
        check("t4_first_pc", got_pc[n], 32'h0000_0200);

        // 5. PC wrap from the top word of the address space.
        mem_lat = 1;
        do_redirect(32'hFFFF_FFFC);
        cycle();
        n = got_pc.size();
        wait_consumed(n + 2, "t5_consume");
        check("t5_pc_top", got_pc[n], 32'hFFFF_FFFC);
        check("t5_pc_wrap", got_pc[n + 1], 32'h0000_0000);

        // 6. Reset mid-request with three queued entries; the stale ack is ignored.
        bus.inst_ready = 1'b0;
        k = 0;
        while (queue_count != 3 && k < 40) begin cycle(); k++; end
        check("t6_fill3", queue_count, 3);
        mem_lat = 3;
        cycle();
        #1;
        check("t6_in_wait", bus.imem_req, 1'b1);
        check("t6_pending", pending, 1'b1);
        reset = 1'b0;
        sb.delete();
        if (pending && bus.imem_ack !== 1'b1) discard_next = 1'b1;
        exp_addr = RESET_PC;
        cycle();
        #1;
        check("t6_rst_req", bus.imem_req, 1'b0);
        check("t6_rst_valid", bus.inst_valid, 1'b0);
        check("t6_rst_data", bus.inst_data, 32'h0);
        check("t6_rst_pc", bus.inst_pc, 32'h0);
        check("t6_rst_count", queue_count, 0);
        cycle();
        #1;
        check("t6_stale_ack", bus.imem_ack, 1'b1);
        cycle();
        reset = 1'b1;
        mem_lat = 1;
        #1;
        check("t6_count_after", queue_count, 0);
        check("t6_req_restart", bus.imem_req, 1'b1);
        check("t6_addr_restart", bus.imem_addr, RESET_PC);
        bus.inst_ready = 1'b1;
        n = got_pc.size();
        wait_consumed(n + 2, "t6_consume");
        check("t6_pc0", got_pc[n], RESET_PC);
        check("t6_pc1", got_pc[n + 1], RESET_PC + 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
